// File: rtl/fft16_result_unloader_if.sv
// Capture and streaming bus of the FFT result unloader.
// master drives frames in and takes beats out; slave is the unloader.
interface fft16_result_unloader_if #(
  parameter int DW = 16
);
  logic             load;
  logic [16*DW-1:0] x_in_packed;
  logic [16*DW-1:0] y_in_packed;
  logic             load_ready;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_re;
  logic [DW-1:0]    out_im;
  logic [3:0]       out_index;
  logic             out_last;
  logic             drop_err;
  logic [7:0]       frame_cnt;

  modport master (
    output load, x_in_packed, y_in_packed, out_ready,
    input  load_ready, out_valid, out_re, out_im, out_index, out_last,
           drop_err, frame_cnt
  );

  modport slave (
    input  load, x_in_packed, y_in_packed, out_ready,
    output load_ready, out_valid, out_re, out_im, out_index, out_last,
           drop_err, frame_cnt
  );
endinterface

// File: rtl/fft16_result_unloader.sv
// Captures one 16-point FFT result frame and streams it one complex bin per beat,
// undoing the butterfly interleave so bins leave in natural order.
module fft16_result_unloader #(
  parameter int DW            = 16,
  parameter bit NATURAL_ORDER = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  fft16_result_unloader_if.slave bus
);
  typedef enum logic {IDLE, STREAM} state_t;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [3:0]    index;
    logic          last;
  } beat_t;

  state_t               state, state_nxt;
  logic [15:0][DW-1:0]  x_buf, y_buf;
  logic [3:0]           ptr;
  beat_t                beat_q, beat_nxt, beat_byp;
  logic                 out_valid_q;
  logic                 drop_err_q;
  logic [7:0]           frame_cnt_q;
  logic                 load_ready, cap, fire_last, adv;

  // Bin b sits in slot {b[2:0], b[3]}: even slots hold bins 0..7, odd slots 8..15.
  function automatic logic [3:0] slot_of(input logic [3:0] b);
    return NATURAL_ORDER ? {b[2:0], b[3]} : b;
  endfunction

  always_comb begin
    fire_last  = out_valid_q && bus.out_ready && beat_q.last;
    load_ready = (state == IDLE) || fire_last;
    cap        = bus.load && load_ready;
    state_nxt  = state;
    adv        = 1'b0;
    case (state)
      IDLE:   if (cap) state_nxt = STREAM;
      STREAM: begin
        if (fire_last && !cap)                         state_nxt = IDLE;
        else if (!fire_last && (!out_valid_q || bus.out_ready)) adv = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    beat_nxt.re    = x_buf[slot_of(ptr)];
    beat_nxt.im    = y_buf[slot_of(ptr)];
    beat_nxt.index = ptr;
    beat_nxt.last  = (ptr == 4'd15);
    // Bin 0 maps to slot 0 in both orders, so a back-to-back frame can start
    // straight from the input vectors without waiting for the buffer.
    beat_byp.re    = bus.x_in_packed[DW-1:0];
    beat_byp.im    = bus.y_in_packed[DW-1:0];
    beat_byp.index = 4'd0;
    beat_byp.last  = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset && cap) begin
      x_buf <= bus.x_in_packed;
      y_buf <= bus.y_in_packed;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      ptr         <= 4'd0;
      drop_err_q  <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      if (fire_last)               frame_cnt_q <= frame_cnt_q + 8'd1;
      if (bus.load && !load_ready) drop_err_q  <= 1'b1;
      if (fire_last && cap) begin
        beat_q      <= beat_byp;
        out_valid_q <= 1'b1;
        ptr         <= 4'd1;
      end else if (fire_last) begin
        out_valid_q <= 1'b0;
        ptr         <= 4'd0;
      end else if (cap) begin
        ptr <= 4'd0;
      end else if (adv) begin
        beat_q      <= beat_nxt;
        out_valid_q <= 1'b1;
        ptr         <= ptr + 4'd1;
      end
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_re     = beat_q.re;
  assign bus.out_im     = beat_q.im;
  assign bus.out_index  = beat_q.index;
  assign bus.out_last   = beat_q.last;
  assign bus.drop_err   = drop_err_q;
  assign bus.frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_fft16_result_unloader.sv
// Scoreboard bench for fft16_result_unloader: natural-order and raw-order instances,
// expected beats queued at load time and popped by per-instance monitors.
module tb_fft16_result_unloader;
  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [3:0]    idx;
    logic          last;
  } beat_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fft16_result_unloader_if #(.DW(DW)) nb ();
  fft16_result_unloader_if #(.DW(DW)) rb ();

  fft16_result_unloader #(.DW(DW), .NATURAL_ORDER(1'b1)) dut_nat (
    .clock(clock), .reset(reset), .bus(nb.slave));
  fft16_result_unloader #(.DW(DW), .NATURAL_ORDER(1'b0)) dut_raw (
    .clock(clock), .reset(reset), .bus(rb.slave));

  beat_t         q_nat[$], q_raw[$];
  int            n_vec = 0, n_err = 0;
  int            hs_nat = 0;
  logic [DW-1:0] fx[16], fy[16];
  logic          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors sample on the falling edge, half a cycle away from the active edge.
  beat_t nat_held, raw_held;
  bit    nat_stall = 0, raw_stall = 0;

  always @(negedge clock) begin
    beat_t cur, e;
    if (reset) nat_stall = 0;
    else if (nb.out_valid) begin
      cur = {nb.out_re, nb.out_im, nb.out_index, nb.out_last};
      if (nat_stall) check("nat_hold", 64'(cur), 64'(nat_held));
      if (nb.out_ready) begin
        hs_nat++;
        nat_stall = 0;
        if (q_nat.size() == 0) check("nat_extra_beat", 64'(cur), 64'hDEAD);
        else begin
          e = q_nat.pop_front();
          check("nat_beat", 64'(cur), 64'(e));
        end
      end else begin
        nat_stall = 1;
        nat_held  = cur;
      end
    end
  end

  always @(negedge clock) begin
    beat_t cur, e;
    if (reset) raw_stall = 0;
    else if (rb.out_valid) begin
      cur = {rb.out_re, rb.out_im, rb.out_index, rb.out_last};
      if (raw_stall) check("raw_hold", 64'(cur), 64'(raw_held));
      if (rb.out_ready) begin
        raw_stall = 0;
        if (q_raw.size() == 0) check("raw_extra_beat", 64'(cur), 64'hDEAD);
        else begin
          e = q_raw.pop_front();
          check("raw_beat", 64'(cur), 64'(e));
        end
      end else begin
        raw_stall = 1;
        raw_held  = cur;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives fx/fy onto the natural instance; bin b expected from slot 2b (b<8) or 2(b-8)+1.
  task automatic nat_load(input bit expect_it);
    beat_t e;
    for (int j = 0; j < 16; j++) begin
      nb.x_in_packed[DW*j +: DW] = fx[j];
      nb.y_in_packed[DW*j +: DW] = fy[j];
    end
    nb.load = 1'b1;
    if (expect_it)
      for (int b = 0; b < 16; b++) begin
        int s;
        s = (b < 8) ? 2*b : 2*(b-8)+1;
        e = {fx[s], fy[s], 4'(b), 1'(b == 15)};
        q_nat.push_back(e);
      end
  endtask

  task automatic raw_load();
    beat_t e;
    for (int j = 0; j < 16; j++) begin
      rb.x_in_packed[DW*j +: DW] = fx[j];
      rb.y_in_packed[DW*j +: DW] = fy[j];
      e = {fx[j], fy[j], 4'(j), 1'(j == 15)};
      q_raw.push_back(e);
    end
    rb.load = 1'b1;
  endtask

  task automatic wait_nat(input logic [7:0] n);
    for (int i = 0; i < 300 && nb.frame_cnt != n; i++) tick();
    check("nat_frame_cnt", 64'(nb.frame_cnt), 64'(n));
  endtask

  task automatic ramp_frame();
    for (int j = 0; j < 16; j++) begin
      fx[j] = DW'(j);
      fy[j] = DW'(-j);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    reset = 1'b1;
    nb.load = 0; nb.x_in_packed = '0; nb.y_in_packed = '0; nb.out_ready = 1'b1;
    rb.load = 0; rb.x_in_packed = '0; rb.y_in_packed = '0; rb.out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", 64'(nb.out_valid), 64'd0);
    check("rst_index", 64'(nb.out_index), 64'd0);
    check("rst_frame_cnt", 64'(nb.frame_cnt), 64'd0);
    check("rst_drop_err", 64'(nb.drop_err), 64'd0);
    check("rst_load_ready", 64'(nb.load_ready), 64'd1);

    // Natural-order ramp frame with one cycle of capture latency.
    ramp_frame();
    nat_load(1);
    tick();
    nb.load = 0;
    check("lat_valid_after_capture", 64'(nb.out_valid), 64'd0);
    tick();
    check("lat_valid_first", 64'(nb.out_valid), 64'd1);
    check("lat_index_first", 64'(nb.out_index), 64'd0);
    wait_nat(8'd1);
    check("nat_queue_empty", 64'(q_nat.size()), 64'd0);

    // Backpressure: ready 1,0,0,1 repeating.
    hs0 = hs_nat;
    nat_load(1);
    for (int k = 0; k < 300; k++) begin
      nb.out_ready = pat[k % 4];
      tick();
      nb.load = 0;
      if (nb.frame_cnt == 8'd2) break;
    end
    nb.out_ready = 1'b1;
    wait_nat(8'd2);
    check("bp_handshakes", 64'(hs_nat - hs0), 64'd16);

    // Back-to-back: B loaded in the cycle of A's last handshake.
    for (int j = 0; j < 16; j++) begin fx[j] = 16'h1111; fy[j] = 16'h1111; end
    nat_load(1);
    tick();
    nb.load = 0;
    for (int i = 0; i < 40 && !(nb.out_valid && nb.out_last); i++) tick();
    check("b2b_load_ready", 64'(nb.load_ready), 64'd1);
    for (int j = 0; j < 16; j++) begin fx[j] = 16'h2222; fy[j] = 16'h2222; end
    nat_load(1);
    tick();
    nb.load = 0;
    check("b2b_valid", 64'(nb.out_valid), 64'd1);
    check("b2b_index", 64'(nb.out_index), 64'd0);
    check("b2b_re", 64'(nb.out_re), 64'h2222);
    wait_nat(8'd4);

    // Overflow: second load during beat 5 is dropped.
    for (int j = 0; j < 16; j++) begin fx[j] = 16'h0100 + DW'(j); fy[j] = 16'hF000 + DW'(j); end
    nat_load(1);
    tick();
    nb.load = 0;
    for (int i = 0; i < 40 && !(nb.out_valid && nb.out_index == 4'd5); i++) tick();
    check("ovf_load_ready", 64'(nb.load_ready), 64'd0);
    for (int j = 0; j < 16; j++) begin fx[j] = 16'hFFFF; fy[j] = 16'hFFFF; end
    nat_load(0);
    tick();
    nb.load = 0;
    check("ovf_drop_err", 64'(nb.drop_err), 64'd1);
    for (int i = 0; i < 40 && !(nb.out_valid && nb.out_last); i++) begin
      check("ovf_load_ready_hold", 64'(nb.load_ready), 64'd0);
      tick();
    end
    wait_nat(8'd5);

    // Reset at beat 7, with a load in the reset cycle that must be ignored.
    for (int j = 0; j < 16; j++) begin fx[j] = 16'h8000 | DW'(j); fy[j] = 16'h7FF0 + DW'(j); end
    nat_load(1);
    tick();
    nb.load = 0;
    for (int i = 0; i < 40 && !(nb.out_valid && nb.out_index == 4'd7); i++) tick();
    nb.out_ready = 1'b0;
    reset = 1'b1;
    nat_load(0);
    tick();
    reset = 1'b0;
    nb.load = 0;
    q_nat.delete();
    check("mid_rst_valid", 64'(nb.out_valid), 64'd0);
    check("mid_rst_index", 64'(nb.out_index), 64'd0);
    check("mid_rst_re", 64'(nb.out_re), 64'd0);
    check("mid_rst_frame_cnt", 64'(nb.frame_cnt), 64'd0);
    check("mid_rst_drop_err", 64'(nb.drop_err), 64'd0);
    tick();
    check("rst_load_ignored", 64'(nb.out_valid), 64'd0);
    nb.out_ready = 1'b1;
    ramp_frame();
    nat_load(1);
    tick();
    nb.load = 0;
    tick();
    check("restart_index", 64'(nb.out_index), 64'd0);
    wait_nat(8'd1);

    // Raw slot order on the second instance.
    ramp_frame();
    raw_load();
    tick();
    rb.load = 0;
    for (int i = 0; i < 300 && rb.frame_cnt != 8'd1; i++) tick();
    check("raw_frame_cnt", 64'(rb.frame_cnt), 64'd1);
    check("raw_queue_empty", 64'(q_raw.size()), 64'd0);
    check("nat_queue_final", 64'(q_nat.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fft16_result_unloader.md
Name: fft16_result_unloader

Overview:
- Consumes the packed 256-bit real/imaginary result vectors produced by the 16-point FFT and streams them out one complex bin per beat over a valid/ready interface.
- Undoes the butterfly-stage interleave, so bins leave in natural order 0..15 (or in raw slot order when NATURAL_ORDER=0).
- Sits directly downstream of the FFT core. Feeds magnitude, windowing or host-readout logic that needs serial samples.

Parameters:
- DW, 16, bits per real/imaginary component. The packed inputs are 16*DW wide.
- NATURAL_ORDER, 1, 1 = emit in bin order 0..15; 0 = emit in packed slot order 0..15.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  capture strobe; asserted for one cycle when the FFT result vectors are valid.
- x_in_packed  in  16*DW  real parts; slot j = bits [DW*j+DW-1 : DW*j].
- y_in_packed  in  16*DW  imaginary parts; same slot layout as x_in_packed.
- load_ready  out  1  capture is accepted this cycle.
- out_valid  out  1  out_re/out_im/out_index/out_last hold a valid beat.
- out_ready  in  1  downstream accepts the beat.
- out_re  out  DW  signed real part of the current bin.
- out_im  out  DW  signed imaginary part of the current bin.
- out_index  out  4  bin number (natural mode) or slot number (raw mode) of the current beat.
- out_last  out  1  high on the beat with out_index = 15.
- drop_err  out  1  sticky; set when load arrives while load_ready is low.
- frame_cnt  out  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Slot mapping, natural mode: bin b is read from slot s = {b[2:0], b[3]}.
  - Bins 0..7 come from slots 0,2,..,14.
  - Bins 8..15 come from slots 1,3,..,15.
- Slot mapping, raw mode: s = b.
- FSM states:
  - IDLE: out_valid = 0, load_ready = 1.
  - STREAM: a frame is held in the capture registers and is being emitted.
- Capture:
  - Condition: load && load_ready.
  - Registers both packed vectors into a 2*16*DW buffer.
  - Sets the read pointer to 0 and enters STREAM.
- load_ready is combinational: (state == IDLE) || (out_valid && out_ready && out_last). Back-to-back frames therefore run with no bubble.
- Latency: capture at edge t -> out_valid = 1 with index 0 after edge t+1.
- Output registers:
  - out_re, out_im, out_index, out_last are registered.
  - They stay stable while out_valid && !out_ready; an AXI-style hold is required.
- Handshake:
  - On out_valid && out_ready the pointer advances to the next index.
  - On the last beat with no new capture: go to IDLE, clear out_valid, increment frame_cnt.
  - Last beat with a simultaneous capture: the new frame's index 0 appears the next cycle, and frame_cnt still increments.
- The pointer counts 0..15 only; there is no wrap inside a frame.
- load with load_ready = 0: ignored, the buffer is untouched, and drop_err is set. drop_err is cleared only by reset.
- Data path: pure routing, with no arithmetic or saturation; sign is preserved bit-exact.
- reset, including mid-frame:
  - Next cycle: state = IDLE; out_valid = 0; out_re = out_im = 0; out_index = 0; out_last = 0; drop_err = 0; frame_cnt = 0.
  - The partial frame is discarded.
  - load in the same cycle as reset is ignored.
- out_ready held high: one beat per cycle, 16 cycles per frame.

Test Plan:
- Natural-order frame, NATURAL_ORDER=1, out_ready=1:
  - Stimulus: load slot j with x = j, y = -j.
  - Required: beats 0..15 give out_re = 0,2,4,..,14,1,3,..,15 and out_im equal to the negatives; out_index = 0..15; out_last only on beat 15; frame_cnt = 1.
- Backpressure:
  - Stimulus: same frame; out_ready toggles 1,0,0,1 repeating.
  - Required: each beat holds stable while stalled, no beat is lost or duplicated, and exactly 16 handshakes complete.
- Back-to-back frames:
  - Stimulus: frame A = all 16'h1111; frame B = all 16'h2222; B's load is asserted in the cycle of A's last handshake.
  - Required: the next beat is B index 0 (0x2222) with no idle cycle; after B completes frame_cnt = 2.
- Overflow:
  - Stimulus: load a second frame during beat 5 of the first.
  - Required: drop_err = 1; beats 6..15 still carry first-frame data; load_ready = 0 throughout.
- Reset mid-frame:
  - Stimulus: assert reset at beat 7.
  - Required: the next cycle shows out_valid = 0, out_index = 0, frame_cnt = 0, drop_err = 0; a following load restarts cleanly at index 0.
- Raw order, NATURAL_ORDER=0:
  - Stimulus: the same frame as the natural-order test.
  - Required: out_re = 0,1,2,..,15 in sequence; out_index = slot number.
